// File: rtl/seg7_pkg.sv
// Seven-segment pattern constants (active-high, bit0=a .. bit6=g) and scan slot indices.
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef enum logic [1:0] {
    SLOT_0 = 2'd0,
    SLOT_1 = 2'd1,
    SLOT_2 = 2'd2
  } slot_t;

endpackage

// File: rtl/bcd_seg_scan_if.sv
// Digit inputs and display outputs of the multiplexed seven-segment scanner.
interface bcd_seg_scan_if;

  logic [3:0] bcd_0;
  logic [3:0] bcd_1;
  logic [3:0] bcd_2;
  logic       en;
  logic [6:0] seg;
  logic [2:0] an;
  logic       frame;

  modport master (output bcd_0, bcd_1, bcd_2, en, input seg, an, frame);
  modport slave  (input bcd_0, bcd_1, bcd_2, en, output seg, an, frame);

endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD to active-high segment pattern; non-BCD codes give a dash, blank gives all off.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_OFF;
    if (!blank) begin
      case (digit)
        4'd0:    pattern = SEG_0;
        4'd1:    pattern = SEG_1;
        4'd2:    pattern = SEG_2;
        4'd3:    pattern = SEG_3;
        4'd4:    pattern = SEG_4;
        4'd5:    pattern = SEG_5;
        4'd6:    pattern = SEG_6;
        4'd7:    pattern = SEG_7;
        4'd8:    pattern = SEG_8;
        4'd9:    pattern = SEG_9;
        default: pattern = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// 3-digit time-multiplexed seven-segment driver; digits snapshotted once per frame,
// leading zeros blanked, guard cycles at each slot start; seg/an/frame registered (1-cycle lag).
module bcd_seg_scan
  import seg7_pkg::*;
#(
  parameter int CLK_DIV        = 50000,
  parameter int GUARD          = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic          clock,
  input  logic          rst_n,
  bcd_seg_scan_if.slave bus
);

  localparam int              PW        = $clog2(CLK_DIV);
  localparam logic [PW-1:0]   PMAX      = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0]   PGUARD    = PW'(GUARD);
  localparam logic [6:0]      SEG_INACT = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [2:0]      AN_INACT  = AN_ACTIVE_LOW ? 3'b111 : 3'b000;

  logic [PW-1:0] pcnt;
  slot_t         slot;
  logic [3:0]    sh0, sh1, sh2;
  logic          tick;
  logic          blank;
  logic          lit;
  logic [3:0]    digit;
  logic [2:0]    an_sel;
  logic [6:0]    pattern;

  always_comb begin
    tick   = (pcnt == PMAX);
    digit  = sh0;
    blank  = 1'b0;
    an_sel = 3'b001;
    case (slot)
      SLOT_1: begin
        digit  = sh1;
        blank  = (sh2 == 4'd0) && (sh1 == 4'd0);
        an_sel = 3'b010;
      end
      SLOT_2: begin
        digit  = sh2;
        blank  = (sh2 == 4'd0);
        an_sel = 3'b100;
      end
      default: ;
    endcase
    // Guard cycles keep the anode dark while segments settle to the new digit.
    lit = bus.en && (pcnt >= PGUARD) && !blank;
  end

  seg7_decode u_decode (
    .digit   (digit),
    .blank   (!lit),
    .pattern (pattern)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      pcnt      <= '0;
      slot      <= SLOT_0;
      sh0       <= 4'd0;
      sh1       <= 4'd0;
      sh2       <= 4'd0;
      bus.frame <= 1'b0;
      bus.seg   <= SEG_INACT;
      bus.an    <= AN_INACT;
    end else begin
      bus.frame <= tick && (slot == SLOT_2);
      bus.seg   <= SEG_ACTIVE_LOW ? ~pattern : pattern;
      bus.an    <= lit ? (AN_ACTIVE_LOW ? ~an_sel : an_sel) : AN_INACT;
      if (tick) begin
        pcnt <= '0;
        case (slot)
          SLOT_0: slot <= SLOT_1;
          SLOT_1: slot <= SLOT_2;
          SLOT_2: begin
            slot <= SLOT_0;
            sh0  <= bus.bcd_0;
            sh1  <= bus.bcd_1;
            sh2  <= bus.bcd_2;
          end
          default: slot <= SLOT_0;
        endcase
      end else begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Directed bench for bcd_seg_scan with CLK_DIV=4, GUARD=1, active-low segments and anodes.
module tb_bcd_seg_scan;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  bcd_seg_scan_if bus ();

  bcd_seg_scan #(
    .CLK_DIV        (4),
    .GUARD          (1),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Cycle c shows the counter state of cycle c-1: pcnt=(c-1)%4, slot=((c-1)/4)%3.
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset(input logic [3:0] b2, input logic [3:0] b1, input logic [3:0] b0);
    rst_n     = 1'b0;
    bus.bcd_2 = b2;
    bus.bcd_1 = b1;
    bus.bcd_0 = b0;
    bus.en    = 1'b1;
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic test_reset();
    logic [2:0] ea;
    logic [6:0] es;
    logic       ef;
    rst_n     = 1'b0;
    bus.bcd_2 = 4'd9;
    bus.bcd_1 = 4'd9;
    bus.bcd_0 = 4'd9;
    bus.en    = 1'b1;
    #13;
    total++;
    if (bus.seg !== 7'h7F || bus.an !== 3'b111 || bus.frame !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold seg=%h an=%b frame=%b want 7f 111 0", bus.seg, bus.an, bus.frame);
    end
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      ea = (c >= 2 && c <= 4) ? 3'b110 : 3'b111;
      es = (c >= 2 && c <= 4) ? 7'h40 : 7'h7F;
      ef = (c == 12);
      total++;
      if (bus.an !== ea || bus.seg !== es || bus.frame !== ef) begin
        bad++;
        $display("FAIL reset_zero c=%0d an=%b seg=%h frame=%b want %b %h %b",
                 c, bus.an, bus.seg, bus.frame, ea, es, ef);
      end
    end
    goto(14);
    total++;
    if (bus.an !== 3'b110 || bus.seg !== 7'h10) begin
      bad++;
      $display("FAIL reset_nine an=%b seg=%h want 110 10", bus.an, bus.seg);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.an !== 3'b111 || bus.seg !== 7'h7F || bus.frame !== 1'b0) begin
      bad++;
      $display("FAIL reset_midslot an=%b seg=%h frame=%b want 111 7f 0", bus.an, bus.seg, bus.frame);
    end
  endtask

  task automatic test_scan_255();
    do_reset(4'd2, 4'd5, 4'd5);
    goto(12);
    total++;
    if (bus.frame !== 1'b1) begin bad++; $display("FAIL s255_frame12 frame=%b want 1", bus.frame); end
    goto(13);
    total++;
    if (bus.an !== 3'b111) begin bad++; $display("FAIL s255_guard0 an=%b want 111", bus.an); end
    goto(14);
    total++;
    if (bus.an !== 3'b110 || bus.seg !== 7'h12) begin
      bad++; $display("FAIL s255_slot0 an=%b seg=%h want 110 12", bus.an, bus.seg);
    end
    goto(17);
    total++;
    if (bus.an !== 3'b111) begin bad++; $display("FAIL s255_guard1 an=%b want 111", bus.an); end
    goto(18);
    total++;
    if (bus.an !== 3'b101 || bus.seg !== 7'h12) begin
      bad++; $display("FAIL s255_slot1 an=%b seg=%h want 101 12", bus.an, bus.seg);
    end
    goto(21);
    total++;
    if (bus.an !== 3'b111) begin bad++; $display("FAIL s255_guard2 an=%b want 111", bus.an); end
    goto(22);
    total++;
    if (bus.an !== 3'b011 || bus.seg !== 7'h24) begin
      bad++; $display("FAIL s255_slot2 an=%b seg=%h want 011 24", bus.an, bus.seg);
    end
    goto(24);
    total++;
    if (bus.frame !== 1'b1 || bus.an !== 3'b011) begin
      bad++; $display("FAIL s255_frame24 frame=%b an=%b want 1 011", bus.frame, bus.an);
    end
  endtask

  task automatic test_leading_zeros();
    do_reset(4'd0, 4'd0, 4'd7);
    goto(14);
    total++;
    if (bus.an !== 3'b110 || bus.seg !== 7'h78) begin
      bad++; $display("FAIL lz007_slot0 an=%b seg=%h want 110 78", bus.an, bus.seg);
    end
    for (int c = 17; c <= 24; c++) begin
      goto(c);
      total++;
      if (bus.an !== 3'b111 || bus.seg !== 7'h7F) begin
        bad++; $display("FAIL lz007_blank c=%0d an=%b seg=%h want 111 7f", c, bus.an, bus.seg);
      end
      if (c == 20) begin
        bus.bcd_1 = 4'd3;
        bus.bcd_0 = 4'd0;
      end
    end
    goto(26);
    total++;
    if (bus.an !== 3'b110 || bus.seg !== 7'h40) begin
      bad++; $display("FAIL lz030_slot0 an=%b seg=%h want 110 40", bus.an, bus.seg);
    end
    goto(30);
    total++;
    if (bus.an !== 3'b101 || bus.seg !== 7'h30) begin
      bad++; $display("FAIL lz030_slot1 an=%b seg=%h want 101 30", bus.an, bus.seg);
    end
    goto(34);
    total++;
    if (bus.an !== 3'b111 || bus.seg !== 7'h7F) begin
      bad++; $display("FAIL lz030_slot2 an=%b seg=%h want 111 7f", bus.an, bus.seg);
    end
  endtask

  task automatic test_invalid_code();
    do_reset(4'd1, 4'hC, 4'd0);
    goto(14);
    total++;
    if (bus.an !== 3'b110 || bus.seg !== 7'h40) begin
      bad++; $display("FAIL inv_slot0 an=%b seg=%h want 110 40", bus.an, bus.seg);
    end
    goto(18);
    total++;
    if (bus.an !== 3'b101 || bus.seg !== 7'h3F) begin
      bad++; $display("FAIL inv_dash an=%b seg=%h want 101 3f", bus.an, bus.seg);
    end
    goto(22);
    total++;
    if (bus.an !== 3'b011 || bus.seg !== 7'h79) begin
      bad++; $display("FAIL inv_slot2 an=%b seg=%h want 011 79", bus.an, bus.seg);
    end
  endtask

  task automatic test_mid_frame_change();
    do_reset(4'd2, 4'd5, 4'd5);
    goto(15);
    bus.bcd_2 = 4'd1;
    bus.bcd_1 = 4'd2;
    bus.bcd_0 = 4'd3;
    goto(16);
    total++;
    if (bus.an !== 3'b110 || bus.seg !== 7'h12) begin
      bad++; $display("FAIL mid_hold0 an=%b seg=%h want 110 12", bus.an, bus.seg);
    end
    goto(18);
    total++;
    if (bus.seg !== 7'h12) begin bad++; $display("FAIL mid_hold1 seg=%h want 12", bus.seg); end
    goto(22);
    total++;
    if (bus.seg !== 7'h24) begin bad++; $display("FAIL mid_hold2 seg=%h want 24", bus.seg); end
    goto(26);
    total++;
    if (bus.an !== 3'b110 || bus.seg !== 7'h30) begin
      bad++; $display("FAIL mid_new0 an=%b seg=%h want 110 30", bus.an, bus.seg);
    end
    goto(30);
    total++;
    if (bus.seg !== 7'h24) begin bad++; $display("FAIL mid_new1 seg=%h want 24", bus.seg); end
    goto(34);
    total++;
    if (bus.an !== 3'b011 || bus.seg !== 7'h79) begin
      bad++; $display("FAIL mid_new2 an=%b seg=%h want 011 79", bus.an, bus.seg);
    end
  endtask

  task automatic test_enable();
    do_reset(4'd2, 4'd5, 4'd5);
    goto(14);
    bus.en = 1'b0;
    goto(15);
    total++;
    if (bus.an !== 3'b111 || bus.seg !== 7'h7F) begin
      bad++; $display("FAIL en_off an=%b seg=%h want 111 7f", bus.an, bus.seg);
    end
    goto(22);
    total++;
    if (bus.an !== 3'b111 || bus.seg !== 7'h7F) begin
      bad++; $display("FAIL en_off_slot2 an=%b seg=%h want 111 7f", bus.an, bus.seg);
    end
    goto(23);
    total++;
    if (bus.frame !== 1'b0) begin bad++; $display("FAIL en_frame23 frame=%b want 0", bus.frame); end
    goto(24);
    total++;
    if (bus.frame !== 1'b1) begin bad++; $display("FAIL en_frame24 frame=%b want 1", bus.frame); end
    goto(36);
    total++;
    if (bus.frame !== 1'b1 || bus.an !== 3'b111) begin
      bad++; $display("FAIL en_frame36 frame=%b an=%b want 1 111", bus.frame, bus.an);
    end
    goto(38);
    bus.en = 1'b1;
    goto(39);
    total++;
    if (bus.an !== 3'b110 || bus.seg !== 7'h12) begin
      bad++; $display("FAIL en_resume an=%b seg=%h want 110 12", bus.an, bus.seg);
    end
  endtask

  initial begin
    test_reset();
    test_scan_255();
    test_leading_zeros();
    test_invalid_code();
    test_mid_frame_change();
    test_enable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_seg_scan.md
# bcd_seg_scan

Time-multiplexed 3-digit seven-segment display driver that consumes the three BCD digits produced by the hex-to-BCD converter stage. It sits directly downstream of that converter. Digits are snapshotted once per refresh frame so the display never tears, leading zeros are blanked, and non-BCD codes show as a dash. The block drives common segment lines plus one enable per digit.

## Interface
- CLK_DIV, 50000: clock cycles per digit slot; must be ≥ 2.
- GUARD, 2: cycles at the start of each slot with all anodes off, for anti-ghosting; 0 ≤ GUARD < CLK_DIV.
- SEG_ACTIVE_LOW, 1: 1 = segment outputs active-low.
- AN_ACTIVE_LOW, 1: 1 = anode outputs active-low.
- clock  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- bcd_0  in  4  units digit.
- bcd_1  in  4  tens digit.
- bcd_2  in  4  hundreds digit.
- en     in  1  display enable; 0 forces the display dark.
- seg    out 7  segments, seg[0]=a … seg[6]=g.
- an     out 3  digit enables, an[i] drives digit i.
- frame  out 1  one-cycle pulse, high the cycle after a snapshot.

## Operation
- Prescaler `pcnt` counts 0..CLK_DIV-1 and wraps. `tick` = (pcnt == CLK_DIV-1).
- Slot counter `slot` is 0→1→2→0 and advances on `tick`.
- Snapshot: on the edge where `tick && slot==2`, latch bcd_0..2 into shadow registers `sh0..sh2`. `frame` is high the following cycle. Input changes at any other time have no visible effect until the next snapshot.
- Digit select: slot s displays `sh_s`.
- Blanking: slot 2 is blank if sh2==0. Slot 1 is blank if sh2==0 and sh1==0. Slot 0 is never blank, so 000 displays "0". A blank slot keeps its anode inactive for the whole slot.
- Decode, active-high gfedcba:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes 10–15 show dash = 40.
  - Inactive = 00.
  - SEG_ACTIVE_LOW inverts all of these.
- Anode for slot s is active iff en && pcnt ≥ GUARD && slot not blank. All other anodes are inactive.
- seg shows the decoded digit whenever its anode is active; otherwise seg is inactive.
- en=0 does not stop pcnt, slot, snapshots, or frame. Only seg and an are forced inactive.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - pcnt=0, slot=0, sh0..2=0, frame=0.
  - seg = inactive (7'h7F when active-low).
  - an = inactive (3'b111 when active-low).
- seg, an, and frame are registered and reflect counter state with a one-cycle lag.
- After reset release, cycle k has pcnt = k mod CLK_DIV. The first snapshot edge is at k = 3·CLK_DIV-1.
- Each slot's lit window is CLK_DIV-GUARD cycles. A frame is 3·CLK_DIV cycles.
- Input-to-display latency: up to one frame to the snapshot, plus one cycle.
- Asserting rst_n low mid-slot blanks the outputs immediately. Operation restarts at slot 0 with a zero shadow, so the display shows "0".

## Structure
- Shared package `seg7_pkg`: the segment pattern constants (digits 0–9, SEG_DASH, SEG_OFF) and the slot-index constants.
- Sub-module `seg7_decode`: combinational; inputs 4-bit digit and blank flag, output 7-bit active-high pattern. Polarity inversion is done in bcd_seg_scan.

## Test plan
All scenarios use CLK_DIV=4, GUARD=1, both polarities active-low.
- Reset: hold rst_n=0 with bcd=9,9,9 → seg=7F, an=111, frame=0. Release: display shows "0" on digit 0 only; frame pulses at cycle 12.
- bcd_2,1,0 = 2,5,5, after first frame:
  - slot 0: an=110, seg=12.
  - slot 1: an=101, seg=12.
  - slot 2: an=011, seg=24.
  - The first cycle of each slot has an=111.
- Leading zeros, bcd=0,0,7: an stays 111 during slots 2 and 1; slot 0 shows an=110, seg=78. With bcd=0,3,0: slot 1 is lit (seg=30) and slot 0 shows seg=40.
- Invalid code bcd_1=4'hC → slot 1 shows dash, seg=3F.
- Change bcd mid-frame → seg is unchanged until after the next frame pulse, then it shows the new value.
- en=0 mid-slot → an=111 and seg=7F on the next cycle, while frame pulses continue every 12 cycles. Re-assert en → display resumes at the current slot.
